collision_detect: RTL and testbench

//  Produces is_collide[3:0] {up,down,left,right} for the player state updater from pos_x/pos_y.

---
 rtl/collision_detect.sv | 150 +++++++++++++++
 tb/tb_collision_detect.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/collision_detect.sv
// Player collision probe scanner.
// Snapshots the hitbox position, probes the 1-bit tile map at 8 edge points
// (two per side) and publishes {up,down,left,right} blocked flags together
// once per 11-cycle scan. Points outside the playfield count as blocked.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LATCH  | capture pos_x/pos_y snapshot, clear side accumulators
// PROBE  | issue probe k=0..7 on map_addr, fold in the sample for k-1
// WAIT   | fold in the sample for probe 7, load the output flags
// UPDATE | flags and collide_valid are presented for this cycle
module collision_detect #(
  parameter int TILE_LOG2 = 5,
  parameter int MAP_COLS  = 25,
  parameter int MAP_ROWS  = 19,
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 600,
  parameter int PLAYER_W  = 20,
  parameter int PLAYER_H  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [9:0] map_addr,
  input  logic       map_data,
  output logic [3:0] is_collide,
  output logic       collide_valid
);

  typedef enum logic [1:0] {
    S_LATCH  = 2'd0,
    S_PROBE  = 2'd1,
    S_WAIT   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  // Probe math carries a spare bit beyond 11-bit signed so x+W on a
  // 10-bit position can never wrap back into the playfield.
  localparam logic signed [11:0] W_S    = 12'(PLAYER_W);
  localparam logic signed [11:0] H_S    = 12'(PLAYER_H);
  localparam logic signed [11:0] ONE_S  = 12'sd1;
  localparam logic signed [11:0] SW_S   = 12'(SCREEN_W);
  localparam logic signed [11:0] SH_S   = 12'(SCREEN_H);
  localparam logic        [11:0] COLS_U = 12'(MAP_COLS);
  localparam logic        [11:0] ROWS_U = 12'(MAP_ROWS);

  state_t      state_q;
  logic [9:0]  x_q, y_q;
  logic [2:0]  k_q;
  logic [3:0]  acc_q, acc_d;
  logic        pend_q;
  logic        pend_oor_q;
  logic [1:0]  pend_side_q;
  logic [3:0]  is_collide_q;
  logic        collide_valid_q;

  logic signed [11:0] sx, sy, px, py;
  logic        [11:0] colf, rowf;
  logic        [9:0]  map_addr_d;
  logic               oor;
  logic               hit;

  assign sx = $signed({2'b00, x_q});
  assign sy = $signed({2'b00, y_q});

  // Probe point for the current slot k, in issue order up,down,left,right.
  always_comb begin
    px = sx;
    py = sy;
    case (k_q)
      3'd0: begin px = sx;               py = sy - ONE_S;       end
      3'd1: begin px = sx + W_S - ONE_S; py = sy - ONE_S;       end
      3'd2: begin px = sx;               py = sy + H_S;         end
      3'd3: begin px = sx + W_S - ONE_S; py = sy + H_S;         end
      3'd4: begin px = sx - ONE_S;       py = sy;               end
      3'd5: begin px = sx - ONE_S;       py = sy + H_S - ONE_S; end
      3'd6: begin px = sx + W_S;         py = sy;               end
      default: begin px = sx + W_S;      py = sy + H_S - ONE_S; end
    endcase
  end

  // Tile address and out-of-range decision for the current probe point.
  always_comb begin
    colf       = 12'(px >>> TILE_LOG2);
    rowf       = 12'(py >>> TILE_LOG2);
    oor        = px[11] || py[11] || (px >= SW_S) || (py >= SH_S) ||
                 (colf >= COLS_U) || (rowf >= ROWS_U);
    map_addr_d = 10'(rowf * COLS_U + colf);
  end

  // Out-of-range slots read nothing and park the address at zero.
  assign map_addr = (state_q == S_PROBE && !oor) ? map_addr_d : 10'd0;

  // Fold the pending sample (issued last cycle) into its side accumulator.
  always_comb begin
    acc_d = acc_q;
    hit   = pend_oor_q | map_data;
    if (pend_q) acc_d[~pend_side_q] = acc_d[~pend_side_q] | hit;
  end

  // Scan sequencer; outputs are registered so a scan is published in one write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_LATCH;
      x_q             <= '0;
      y_q             <= '0;
      k_q             <= '0;
      acc_q           <= '0;
      pend_q          <= 1'b0;
      pend_oor_q      <= 1'b0;
      pend_side_q     <= '0;
      is_collide_q    <= '0;
      collide_valid_q <= 1'b0;
    end else begin
      collide_valid_q <= 1'b0;
      pend_q          <= 1'b0;
      case (state_q)
        S_LATCH: begin
          x_q     <= pos_x;
          y_q     <= pos_y;
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= S_PROBE;
        end
        S_PROBE: begin
          acc_q       <= acc_d;
          pend_q      <= 1'b1;
          pend_oor_q  <= oor;
          pend_side_q <= k_q[2:1];
          k_q         <= k_q + 3'd1;
          if (k_q == 3'd7) state_q <= S_WAIT;
        end
        S_WAIT: begin
          acc_q           <= acc_d;
          is_collide_q    <= acc_d;
          collide_valid_q <= 1'b1;
          state_q         <= S_UPDATE;
        end
        default: begin
          state_q <= S_LATCH;
        end
      endcase
    end
  end

  assign is_collide    = is_collide_q;
  assign collide_valid = collide_valid_q;

endmodule

// File: tb/tb_collision_detect.sv
// Bench for collision_detect: sync tile ROM model, directed scenarios and
// randomized scans checked against a geometric reference model.
module tb_collision_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pos_x, pos_y;
  logic [9:0] map_addr;
  logic       map_data = 1'b0;
  logic [3:0] is_collide;
  logic       collide_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_flags = 0;

  bit mem [0:474];

  collision_detect dut (
    .clk          (clk),
    .rst          (rst),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .map_addr     (map_addr),
    .map_data     (map_data),
    .is_collide   (is_collide),
    .collide_valid(collide_valid)
  );

  always #5 clk = ~clk;

  // Synchronous map ROM, data valid one cycle after the address.
  always @(posedge clk)
    map_data <= (map_addr < 10'd475) ? mem[map_addr] : 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: geometry straight from the probe rules ----
  function automatic int ref_px(input int x, input int k);
    case (k)
      0, 2:    return x;
      1, 3:    return x + 20 - 1;
      4, 5:    return x - 1;
      default: return x + 20;
    endcase
  endfunction

  function automatic int ref_py(input int y, input int k);
    case (k)
      0, 1:    return y - 1;
      2, 3:    return y + 20;
      4, 6:    return y;
      default: return y + 20 - 1;
    endcase
  endfunction

  function automatic bit ref_out(input int px, input int py);
    return (px < 0) || (px >= 800) || (py < 0) || (py >= 600);
  endfunction

  function automatic int ref_addr(input int x, input int y, input int k);
    int px, py;
    px = ref_px(x, k);
    py = ref_py(y, k);
    if (ref_out(px, py)) return 0;
    return (py / 32) * 25 + (px / 32);
  endfunction

  function automatic int ref_flags(input int x, input int y);
    int f;
    bit h;
    f = 0;
    for (int k = 0; k < 8; k++) begin
      h = ref_out(ref_px(x, k), ref_py(y, k)) ? 1'b1 : mem[ref_addr(x, y, k)];
      if (h) f = f | (8 >> (k / 2));
    end
    return f;
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 475; i++) mem[i] = 1'b0;
  endtask

  task automatic set_tile(input int col, input int row);
    mem[row * 25 + col] = 1'b1;
  endtask

  // Called at the negedge of a LATCH cycle; returns at the next LATCH negedge.
  task automatic scan(input int x, input int y, input int hand,
                      input int chg_cycle, input int nx, input int ny,
                      input int abort_cycle);
    int exp;
    exp   = ref_flags(x, y);
    pos_x = 10'(x);
    pos_y = 10'(y);
    check("cv_latch", collide_valid, 0);
    check("hold_latch", is_collide, prev_flags);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 8) check($sformatf("addr_k%0d", c - 1), map_addr, ref_addr(x, y, c - 1));
      if (c == chg_cycle) begin
        pos_x = 10'(nx);
        pos_y = 10'(ny);
      end
      if (c < 10) begin
        check("cv_low", collide_valid, 0);
        check("hold", is_collide, prev_flags);
      end else begin
        check("cv_pulse", collide_valid, 1);
        check("flags", is_collide, exp);
        if (hand >= 0) check("flags_dir", is_collide, hand);
      end
      if (c == abort_cycle) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_flags", is_collide, 0);
        check("abort_cv", collide_valid, 0);
        check("abort_addr", map_addr, 0);
        rst = 1'b0;
        prev_flags = 0;
        return;
      end
    end
    prev_flags = exp;
    @(negedge clk);
  endtask

  initial begin
    int x, y;
    rst   = 1'b1;
    pos_x = '0;
    pos_y = '0;
    clear_map();
    repeat (3) @(negedge clk);
    check("rst_flags", is_collide, 0);
    check("rst_cv", collide_valid, 0);
    check("rst_addr", map_addr, 0);
    rst = 1'b0;

    // bottom row solid
    for (int c = 0; c < 25; c++) set_tile(c, 18);
    scan(200, 556, 4'b0100, -1, 0, 0, -1);

    // playfield edges on an empty map
    clear_map();
    scan(0,   300, 4'b0010, -1, 0, 0, -1);
    scan(780, 300, 4'b0001, -1, 0, 0, -1);
    scan(300, 0,   4'b1000, -1, 0, 0, -1);

    // right-edge boundary against a single tile
    clear_map();
    set_tile(7, 5);
    scan(204, 160, 4'b0001, -1, 0, 0, -1);
    scan(203, 160, 4'b0000, -1, 0, 0, -1);

    // up probe at y-1 crossing into the tile above
    clear_map();
    set_tile(6, 5);
    scan(192, 192, 4'b1000, -1, 0, 0, -1);

    // position change mid-scan is ignored until the next LATCH
    clear_map();
    for (int c = 0; c < 25; c++) set_tile(c, 18);
    scan(200, 556, 4'b0100, 3, 400, 100, -1);
    scan(400, 100, 4'b0000, -1, 0, 0, -1);

    // reset in the middle of a scan
    scan(200, 556, -1, -1, 0, 0, 5);
    scan(200, 556, 4'b0100, -1, 0, 0, -1);

    // randomized maps and positions
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 475; i++) mem[i] = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
        1: begin x = $urandom_range(0, 40);   y = $urandom_range(0, 599);  end
        2: begin x = $urandom_range(760, 799); y = $urandom_range(560, 620); end
        default: begin x = $urandom_range(0, 799); y = $urandom_range(0, 599); end
      endcase
      scan(x, y, -1, (n % 3 == 0) ? 4 : -1,
           $urandom_range(0, 1023), $urandom_range(0, 1023), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
